sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised successor to the team's basic synchronous FIFO: single-clock, any depth (power of two not required), configurable thresholds, occupancy count and error flags.
- Two read modes: standard (registered read, 1-cycle latency) and first-word-fall-through (FWFT).
- Sits between producer and consumer blocks in one clock domain, as the generic buffering primitive for stream datapaths.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- FIFO_DEPTH, 10, number of entries. Must be >= 2; any integer is legal.
- AF_TH, FIFO_DEPTH-2, almost_full asserts when count >= AF_TH. Legal range 1..FIFO_DEPTH.
- AE_TH, 2, almost_empty asserts when count <= AE_TH. Legal range 0..FIFO_DEPTH-1.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.
- CNT_W, $clog2(FIFO_DEPTH+1), width of count (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- wt_ena  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_ena  in  1  read request (standard) / pop head (FWFT).
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a valid word.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  one-cycle pulse on a rejected write.
- underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pointers 0, count 0, data_out 0, data_valid 0, overflow 0, underflow 0.
  - Flags after reset: empty 1, full 0, almost_empty 1, almost_full 0 (given AF_TH >= 1).
  - Memory is not reset.
- Reset mid-operation discards all contents; the next cycle behaves as post-reset.
- Accept rules, evaluated on the same edge:
  - rd_acc = rd_ena && !empty.
  - wr_acc = wt_ena && (!full || rd_acc). Simultaneous read and write when full is legal: both are accepted and count is unchanged.
  - When empty, a simultaneous read is rejected (no write-to-read bypass). The write is accepted and count becomes 1.
- Pointers: wr_ptr and rd_ptr range 0..FIFO_DEPTH-1.
  - Each increments on accept and wraps from FIFO_DEPTH-1 to 0 by explicit compare (no modulo-2^n).
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - All flags decode combinationally from the registered count. No pointer-MSB comparison.
- overflow = registered (wt_ena && full && !rd_ena). underflow = registered (rd_ena && empty). Both last one cycle and are not sticky.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 on the next edge (latency 1).
  - Otherwise data_valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
  - rd_ena acts as a pop: the next word appears the cycle after the pop.
  - A word written into an empty FIFO is visible on data_out one cycle after the write edge.
- Write-then-read of the same entry is not possible: an empty FIFO blocks the read, and a full FIFO reads the old entry before the write lands.
- Full wrap: after FIFO_DEPTH writes and FIFO_DEPTH reads, pointers return to 0 with data order preserved.

Decomposition:
- Package sync_fifo_pkg:
  - Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - Function fifo_cnt_w(depth) returning $clog2(depth+1).
  - Elaboration-time parameter checks (depth >= 2, threshold ranges).
- Sub-module fifo_mem: simple dual-port register array, FIFO_DEPTH x DATA_WIDTH.
  - One synchronous write port and one asynchronous read port.
  - The top-level adds the output register in standard mode.

Test Plan:
- Reset, then write 0x11,0x22,0x33 and read 3 (STD, DEPTH=10) -> data_out 0x11,0x22,0x33, each with data_valid one cycle after rd_ena; count 3→0; empty=1 at end.
- Fill with 10 writes, then an 11th write with rd_ena=0 -> full=1, count=10, overflow pulses once, 11th word not stored; subsequent reads return the first 10 in order.
- With full, assert wt_ena=rd_ena=1 writing 0xAA -> count stays 10, oldest word read out, 0xAA appears as the 10th read later; no overflow.
- Read when empty -> underflow pulses 1 cycle, data_valid=0, count=0. Then simultaneous wr 0x5 + rd -> read rejected, count=1.
- Thresholds AF_TH=8, AE_TH=2 -> almost_empty drops when count 2→3; almost_full rises when count 7→8; 25 wr/rd cycles at DEPTH=10 check wrap at entry 9→0 with data order intact.
- FWFT=1, write 0x7 into empty -> data_out=0x7, data_valid=1 the next cycle without rd_ena; pop -> data_valid=0. Assert rst mid-fill -> count=0 and empty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Provides read-mode constants, count-width helper and parameter sanity checks.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit fifo_params_ok(
        input int depth,
        input int af_th,
        input int ae_th,
        input int mode
    );
        return (depth >= 2)
            && (af_th >= 1) && (af_th <= depth)
            && (ae_th >= 0) && (ae_th <= depth - 1)
            && ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO.
// One synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 10,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary depth with thresholds, count and error pulses.
// Supports registered (standard) and first-word-fall-through read modes.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 10,
    parameter int AF_TH      = FIFO_DEPTH - 2,
    parameter int AE_TH      = 2,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wt_ena,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_ena,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (!fifo_params_ok(FIFO_DEPTH, AF_TH, AE_TH, FWFT)) begin : g_bad_params
        $error("sync_fifo_param: illegal parameter set");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO may still take a write when the same edge frees a slot.
    assign rd_acc = rd_ena && !empty;
    assign wr_acc = wt_ena && (!full || rd_acc);

    assign full         = (count == CNT_W'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_TH));
    assign almost_empty = (count <= CNT_W'(AE_TH));

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1))
                        ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1))
                        ? '0 : rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= wt_ena && full && !rd_ena;
            underflow <= rd_ena && empty;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_out   = rd_data;
        assign data_valid = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dv_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
                dv_q   <= 1'b1;
            end else begin
                dv_q   <= 1'b0;
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dv_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances driven in lockstep
// and compared against a queue-based model of the FIFO behaviour.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AF    = 8;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wt_ena;
    logic [DW-1:0] data_in;
    logic          rd_ena;

    logic [DW-1:0] s_dout;
    logic          s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [CW-1:0] s_cnt;

    logic [DW-1:0] f_dout;
    logic          f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] e_dout;
    logic          e_dv, e_ovf, e_unf;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH),
        .AF_TH (AF), .AE_TH (AE), .FWFT (0)
    ) u_std (
        .clk (clk), .rst (rst), .wt_ena (wt_ena), .data_in (data_in),
        .rd_ena (rd_ena), .data_out (s_dout), .data_valid (s_dv),
        .full (s_full), .empty (s_empty), .almost_full (s_af),
        .almost_empty (s_ae), .count (s_cnt),
        .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo_param #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH),
        .AF_TH (AF), .AE_TH (AE), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wt_ena (wt_ena), .data_in (data_in),
        .rd_ena (rd_ena), .data_out (f_dout), .data_valid (f_dv),
        .full (f_full), .empty (f_empty), .almost_full (f_af),
        .almost_empty (f_ae), .count (f_cnt),
        .overflow (f_ovf), .underflow (f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count", 32'(s_cnt), 32'(n));
        chk("std_empty", 32'(s_empty), 32'(n == 0));
        chk("std_full", 32'(s_full), 32'(n == DEPTH));
        chk("std_af", 32'(s_af), 32'(n >= AF));
        chk("std_ae", 32'(s_ae), 32'(n <= AE));
        chk("std_ovf", 32'(s_ovf), 32'(e_ovf));
        chk("std_unf", 32'(s_unf), 32'(e_unf));
        chk("std_dv", 32'(s_dv), 32'(e_dv));
        chk("std_dout", 32'(s_dout), 32'(e_dout));
        chk("fwft_count", 32'(f_cnt), 32'(n));
        chk("fwft_empty", 32'(f_empty), 32'(n == 0));
        chk("fwft_full", 32'(f_full), 32'(n == DEPTH));
        chk("fwft_af", 32'(f_af), 32'(n >= AF));
        chk("fwft_ae", 32'(f_ae), 32'(n <= AE));
        chk("fwft_ovf", 32'(f_ovf), 32'(e_ovf));
        chk("fwft_unf", 32'(f_unf), 32'(e_unf));
        chk("fwft_dv", 32'(f_dv), 32'(n > 0));
        if (n > 0) chk("fwft_dout", 32'(f_dout), 32'(q[0]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wt_ena = 1'b0;
        rd_ena = 1'b0;
        data_in = '0;
        q.delete();
        e_dout = '0;
        e_dv = 1'b0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d,
                        input logic r);
        int  n;
        bit  ra, wa;
        rst = 1'b0;
        wt_ena = w;
        data_in = d;
        rd_ena = r;
        n = q.size();
        ra = r && (n > 0);
        wa = w && ((n < DEPTH) || ra);
        e_ovf = w && (n == DEPTH) && !r;
        e_unf = r && (n == 0);
        if (ra) begin
            e_dout = q.pop_front();
            e_dv = 1'b1;
        end else begin
            e_dv = 1'b0;
        end
        if (wa) q.push_back(d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        wt_ena = 1'b0;
        rd_ena = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;
        do_reset();

        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0);
        step(1, 8'hEE, 0);
        step(0, 8'h00, 0);
        step(1, 8'hAA, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);

        step(0, 8'h00, 1);
        step(1, 8'h05, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);

        step(1, 8'hC0, 0);
        for (int i = 1; i <= 25; i++) step(1, 8'(8'hC0 + i), 1);
        step(0, 8'h00, 1);

        for (int i = 0; i < 300; i++) begin
            logic w, r;
            if (i < 150) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, 8'($urandom), r);
        end

        do_reset();
        step(1, 8'h07, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0);
        do_reset();
        step(0, 8'h00, 0);
        step(1, 8'h3C, 0);
        step(0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
